// File: rtl/capture_deserializer.sv
// capture_deserializer
//   Multi-channel logic-capture deserializer. Every channel is sampled on a
//   common decimated strobe (one sample every div+1 clocks). Each channel
//   accumulates DEPTH samples in its own shift register. A completed word is
//   presented on a valid/ready output register. If a word completes while the
//   output register still holds an unconsumed word, the new word is dropped and
//   a sticky overflow flag is set.
//
// Parameters
//   NCH   : number of input channels (1..64)
//   DEPTH : samples per channel per output word (2..32)
//   DIV_W : width of the sample-rate divider
//
// Ports
//   clk       : rising-edge clock for all state
//   rst_n     : asynchronous active-low reset
//   channels  : raw channel levels, sampled without a synchronizer
//   enable    : capture run; when low, divider/fill/shift state is cleared
//   div       : sample period minus one, in clocks
//   clr_ovf   : clears the sticky overflow flag (a new overflow wins)
//   out_ready : consumer accepts the word held on out_data
//   out_valid : out_data holds an unconsumed word
//   out_data  : completed word, bit i*DEPTH+k = channel i, k=0 newest sample
//   overflow  : sticky, at least one completed word was dropped
module capture_deserializer #(
  parameter int NCH   = 32,
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         channels,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       div,
  input  logic                   clr_ovf,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [NCH*DEPTH-1:0]   out_data,
  output logic                   overflow
);

  localparam int W      = NCH * DEPTH;
  localparam int FILL_W = $clog2(DEPTH);

  logic [DIV_W-1:0]  div_cnt;
  logic [FILL_W-1:0] fill;
  logic [W-1:0]      sr;
  logic [W-1:0]      sr_next;
  logic              strobe;
  logic              complete;
  logic              transfer;

  // >= rather than == so that lowering div below the running count ends the
  // current period immediately instead of waiting for the counter to wrap.
  always_comb begin
    strobe = enable && (div_cnt >= div);
  end

  // Per-channel left shift; the newest sample enters at bit k=0.
  always_comb begin
    sr_next = sr;
    for (int unsigned i = 0; i < NCH; i++) begin
      sr_next[i*DEPTH +: DEPTH] = {sr[i*DEPTH +: DEPTH-1], channels[i]};
    end
  end

  always_comb begin
    complete = strobe && (fill == FILL_W'(DEPTH - 1));
    transfer = out_valid && out_ready;
  end

  // Capture datapath: divider, fill counter and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      fill    <= '0;
      sr      <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      fill    <= '0;
      sr      <= '0;
    end else begin
      if (strobe) begin
        div_cnt <= '0;
        sr      <= sr_next;
        fill    <= complete ? '0 : fill + FILL_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Output register. A completion loads the word (taking sr_next so the
  // completing sample is included) whenever the register is empty or being
  // drained in the same clock; otherwise the word is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (complete && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_data  <= sr_next;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end

      if (complete && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
